// File: rtl/tictactoe_pkg.sv
// Shared encodings for the tictactoe move-entry stage: marks, results,
// entry FSM states, the out-of-range coordinate and small helper functions.
package tictactoe_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        X     = 2'b01,
        O     = 2'b10
    } mark_t;

    typedef enum logic [1:0] {
        NONE = 2'b00,
        XWIN = 2'b01,
        OWIN = 2'b10,
        DRAW = 2'b11
    } win_t;

    typedef enum logic [2:0] {
        ST_INIT       = 3'd0,
        ST_WAIT_PRESS = 3'd1,
        ST_ISSUE      = 3'd2,
        ST_WAIT_RESP  = 3'd3,
        ST_AI_WAIT    = 3'd4,
        ST_DONE       = 3'd5
    } entry_state_t;

    localparam logic [1:0] COORD_INVALID = 2'd3;
    localparam logic [3:0] MAX_MOVES     = 4'd9;

    // Move counter increment that sticks at a full board.
    function automatic logic [3:0] sat_inc(input logic [3:0] v);
        if (v >= MAX_MOVES) begin
            return MAX_MOVES;
        end else begin
            return v + 4'd1;
        end
    endfunction

    // Linear board cell index, row-major, 0..8 for in-range coordinates.
    function automatic logic [3:0] cell_index(input logic [1:0] row, input logic [1:0] col);
        return ({2'b00, row} * 4'd3) + {2'b00, col};
    endfunction

endpackage

// File: rtl/tictactoe_move_entry_button_debounce.sv
// Button conditioning: two-flop synchronizer, then a level filter that
// accepts a new level only after DEB_CYCLES consecutive stable samples.
// Emits a one-cycle registered pulse on each accepted rising level.
module button_debounce #(
    parameter int DEB_CYCLES = 16
) (
    input  logic ph1,
    input  logic resetb,
    input  logic btn_raw,
    output logic rise
);

    localparam int CW = $clog2(DEB_CYCLES + 1);

    logic          sync1_r;
    logic          sync2_r;
    logic          level_r;
    logic [CW-1:0] cnt_r;
    logic          rise_r;

    // Synchronize the raw button and filter it into a stable level.
    always_ff @(posedge ph1) begin
        if (!resetb) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
            level_r <= 1'b0;
            cnt_r   <= '0;
            rise_r  <= 1'b0;
        end else begin
            sync1_r <= btn_raw;
            sync2_r <= sync1_r;
            rise_r  <= 1'b0;
            if (sync2_r == level_r) begin
                cnt_r <= '0;
            end else if (cnt_r == CW'(DEB_CYCLES - 1)) begin
                level_r <= sync2_r;
                cnt_r   <= '0;
                rise_r  <= sync2_r;
            end else begin
                cnt_r <= cnt_r + CW'(1);
            end
        end
    end

    assign rise = rise_r;

endmodule

// File: rtl/tictactoe_move_entry.sv
// Move-entry stage in front of the tictactoe core. Turns debounced button
// presses into single-cycle move requests, tracks the side to move, waits
// for the core's verdict and, in AI mode, for the core's O reply.
// Optional build macro MOVE_ENTRY_LOCAL_CHECK_EN adds a local occupancy map
// that rejects places on taken cells before they reach the core.
module tictactoe_move_entry
    import tictactoe_pkg::*;
#(
    parameter int DEB_CYCLES = 16,
    parameter int RESP_LAT   = 1,
    parameter int AI_TIMEOUT = 8
) (
    input  logic       ph1,
    input  logic       resetb,
    input  logic [1:0] sw_row,
    input  logic [1:0] sw_col,
    input  logic       btn_place,
    input  logic       btn_new,
    input  logic       ai_mode,
    input  logic       core_err,
    input  logic [1:0] core_win,
    input  logic [1:0] core_xoro,
    output logic       core_reset,
    output logic [1:0] xoroin,
    output logic [1:0] rowin,
    output logic [1:0] colin,
    output logic       ai_en,
    output logic [1:0] turn,
    output logic       busy,
    output logic       game_over,
    output logic       reject,
    output logic [3:0] move_count
);

    logic place_pulse_s;
    logic new_pulse_s;

    entry_state_t state_r, state_nx;
    mark_t        turn_r, turn_nx;
    logic [7:0]   timer_r, timer_nx;
    logic [3:0]   count_r, count_nx;
    logic [1:0]   xoroin_r, xoroin_nx;
    logic [1:0]   rowin_r, rowin_nx;
    logic [1:0]   colin_r, colin_nx;
    logic         ai_en_r, ai_en_nx;
    logic         core_reset_r, core_reset_nx;
    logic         busy_r, busy_nx;
    logic         game_over_r, game_over_nx;
    logic         reject_r, reject_nx;
    logic         accept_player_s;
    logic         accept_ai_s;
    logic         occupied_s;

    button_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_place (
        .ph1     (ph1),
        .resetb  (resetb),
        .btn_raw (btn_place),
        .rise    (place_pulse_s)
    );

    button_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_new (
        .ph1     (ph1),
        .resetb  (resetb),
        .btn_raw (btn_new),
        .rise    (new_pulse_s)
    );

`ifdef MOVE_ENTRY_LOCAL_CHECK_EN
    logic [8:0] occ_r, occ_nx;

    // Occupancy map: cleared on a new game, marked on every accepted move.
    always_comb begin
        occ_nx = occ_r;
        if (new_pulse_s || state_r == ST_INIT) begin
            occ_nx = 9'd0;
        end else if (accept_player_s) begin
            occ_nx[cell_index(rowin_r, colin_r)] = 1'b1;
        end else if (accept_ai_s) begin
            occ_nx[cell_index(rowin_r, colin_r)] = 1'b1;
        end else begin
            occ_nx = occ_r;
        end
    end

    // Occupancy map register.
    always_ff @(posedge ph1) begin
        if (!resetb) begin
            occ_r <= 9'd0;
        end else begin
            occ_r <= occ_nx;
        end
    end

    assign occupied_s = occ_r[cell_index(sw_row, sw_col)];
`else
    assign occupied_s = 1'b0;
`endif

    // Next-state, turn and move-latch logic; btn_new overrides everything.
    always_comb begin
        state_nx        = state_r;
        turn_nx         = turn_r;
        timer_nx        = timer_r;
        rowin_nx        = rowin_r;
        colin_nx        = colin_r;
        ai_en_nx        = ai_en_r;
        reject_nx       = 1'b0;
        accept_player_s = 1'b0;
        accept_ai_s     = 1'b0;
        if (new_pulse_s) begin
            state_nx = ST_INIT;
            timer_nx = 8'd0;
            turn_nx  = X;
        end else begin
            case (state_r)
                ST_INIT: begin
                    turn_nx  = X;
                    ai_en_nx = 1'b0;
                    if (timer_r == 8'd1) begin
                        state_nx = ST_WAIT_PRESS;
                        timer_nx = 8'd0;
                    end else begin
                        timer_nx = timer_r + 8'd1;
                    end
                end
                ST_WAIT_PRESS: begin
                    if (place_pulse_s) begin
                        if (sw_row == COORD_INVALID || sw_col == COORD_INVALID) begin
                            reject_nx = 1'b1;
                        end else if (occupied_s) begin
                            reject_nx = 1'b1;
                        end else begin
                            rowin_nx = sw_row;
                            colin_nx = sw_col;
                            ai_en_nx = ai_mode;
                            state_nx = ST_ISSUE;
                        end
                    end else begin
                        state_nx = ST_WAIT_PRESS;
                    end
                end
                ST_ISSUE: begin
                    state_nx = ST_WAIT_RESP;
                    timer_nx = 8'd1;
                end
                ST_WAIT_RESP: begin
                    if (timer_r >= 8'(RESP_LAT)) begin
                        if (core_err) begin
                            reject_nx = 1'b1;
                            state_nx  = ST_WAIT_PRESS;
                        end else begin
                            accept_player_s = 1'b1;
                            if (core_win != NONE) begin
                                state_nx = ST_DONE;
                            end else if (ai_mode && turn_r == X) begin
                                turn_nx  = O;
                                timer_nx = 8'd0;
                                state_nx = ST_AI_WAIT;
                            end else begin
                                turn_nx  = (turn_r == X) ? O : X;
                                state_nx = ST_WAIT_PRESS;
                            end
                        end
                    end else begin
                        timer_nx = timer_r + 8'd1;
                    end
                end
                ST_AI_WAIT: begin
                    if (core_xoro == O) begin
                        accept_ai_s = 1'b1;
                        turn_nx     = X;
                        state_nx    = (core_win != NONE) ? ST_DONE : ST_WAIT_PRESS;
                    end else if (timer_r == 8'(AI_TIMEOUT - 1)) begin
                        turn_nx  = X;
                        state_nx = ST_WAIT_PRESS;
                    end else begin
                        timer_nx = timer_r + 8'd1;
                    end
                end
                ST_DONE: begin
                    state_nx = ST_DONE;
                end
                default: begin
                    state_nx = ST_INIT;
                    timer_nx = 8'd0;
                end
            endcase
        end
    end

    // Move counter: cleared by a new game, saturating on accepted moves.
    always_comb begin
        if (new_pulse_s || state_r == ST_INIT) begin
            count_nx = 4'd0;
        end else if (accept_player_s || accept_ai_s) begin
            count_nx = sat_inc(count_r);
        end else begin
            count_nx = count_r;
        end
    end

    // Output decode from the next state so registered outputs line up with the state.
    always_comb begin
        xoroin_nx     = (state_nx == ST_ISSUE) ? turn_nx : EMPTY;
        core_reset_nx = (state_nx == ST_INIT);
        game_over_nx  = (state_nx == ST_DONE);
        case (state_nx)
            ST_INIT, ST_ISSUE, ST_WAIT_RESP, ST_AI_WAIT: busy_nx = 1'b1;
            default:                                     busy_nx = 1'b0;
        endcase
    end

    // State and registered-output update.
    always_ff @(posedge ph1) begin
        if (!resetb) begin
            state_r      <= ST_INIT;
            turn_r       <= X;
            timer_r      <= 8'd0;
            count_r      <= 4'd0;
            xoroin_r     <= 2'b00;
            rowin_r      <= 2'b00;
            colin_r      <= 2'b00;
            ai_en_r      <= 1'b0;
            core_reset_r <= 1'b1;
            busy_r       <= 1'b0;
            game_over_r  <= 1'b0;
            reject_r     <= 1'b0;
        end else begin
            state_r      <= state_nx;
            turn_r       <= turn_nx;
            timer_r      <= timer_nx;
            count_r      <= count_nx;
            xoroin_r     <= xoroin_nx;
            rowin_r      <= rowin_nx;
            colin_r      <= colin_nx;
            ai_en_r      <= ai_en_nx;
            core_reset_r <= core_reset_nx;
            busy_r       <= busy_nx;
            game_over_r  <= game_over_nx;
            reject_r     <= reject_nx;
        end
    end

    assign core_reset = core_reset_r;
    assign xoroin     = xoroin_r;
    assign rowin      = rowin_r;
    assign colin      = colin_r;
    assign ai_en      = ai_en_r;
    assign turn       = turn_r;
    assign busy       = busy_r;
    assign game_over  = game_over_r;
    assign reject     = reject_r;
    assign move_count = count_r;

endmodule

// File: tb/tb_tictactoe_move_entry.sv
// Directed bench for tictactoe_move_entry with hand-computed expectations.
module tb_tictactoe_move_entry;

    logic       ph1 = 1'b0;
    logic       resetb;
    logic [1:0] sw_row, sw_col;
    logic       btn_place, btn_new, ai_mode, core_err;
    logic [1:0] core_win, core_xoro;
    logic       core_reset, ai_en, busy, game_over, reject;
    logic [1:0] xoroin, rowin, colin, turn;
    logic [3:0] move_count;

    int checks = 0;
    int errors = 0;

    int issue_cnt, reject_cnt, busy_seen, rst_cycles, iss_c, first_rst_c;
    logic [1:0] iss_x, iss_row, iss_col;
    logic       iss_ai;
    logic [1:0] turn_log [0:199];
    logic       busy_log [0:199];

    tictactoe_move_entry dut (
        .ph1(ph1), .resetb(resetb), .sw_row(sw_row), .sw_col(sw_col),
        .btn_place(btn_place), .btn_new(btn_new), .ai_mode(ai_mode),
        .core_err(core_err), .core_win(core_win), .core_xoro(core_xoro),
        .core_reset(core_reset), .xoroin(xoroin), .rowin(rowin), .colin(colin),
        .ai_en(ai_en), .turn(turn), .busy(busy), .game_over(game_over),
        .reject(reject), .move_count(move_count)
    );

    always #5 ph1 = ~ph1;

    // Drive buttons/AI reply per cycle and record what the DUT shows on each falling edge.
    task automatic run_seq(input int place_on, input int place_off, input int new_on,
                           input int new_off, input int reply_delay, input int total);
        issue_cnt = 0; reject_cnt = 0; busy_seen = 0; rst_cycles = 0;
        iss_c = -1; first_rst_c = -1;
        iss_x = 2'b00; iss_row = 2'b00; iss_col = 2'b00; iss_ai = 1'b0;
        for (int c = 0; c < total; c++) begin
            @(negedge ph1);
            turn_log[c] = turn;
            busy_log[c] = busy;
            if (xoroin !== 2'b00) begin
                issue_cnt++; iss_c = c;
                iss_x = xoroin; iss_row = rowin; iss_col = colin; iss_ai = ai_en;
            end
            if (reject === 1'b1) reject_cnt++;
            if (busy === 1'b1) busy_seen++;
            if (core_reset === 1'b1) begin
                rst_cycles++;
                if (first_rst_c < 0) first_rst_c = c;
            end
            btn_place = (c >= place_on && c < place_off);
            btn_new   = (c >= new_on && c < new_off);
            core_xoro = (reply_delay > 0 && iss_c >= 0 && c == iss_c + reply_delay) ? 2'b10 : 2'b00;
        end
    endtask

    task automatic test_reset();
        resetb = 1'b0; sw_row = 2'd0; sw_col = 2'd0; btn_place = 1'b0; btn_new = 1'b0;
        ai_mode = 1'b0; core_err = 1'b0; core_win = 2'b00; core_xoro = 2'b00;
        repeat (3) @(negedge ph1);
        checks++; if (core_reset !== 1'b1) begin errors++; $display("FAIL reset_core_reset: got %0b expected 1", core_reset); end
        checks++; if (turn !== 2'b01) begin errors++; $display("FAIL reset_turn: got %0b expected 01", turn); end
        checks++; if (move_count !== 4'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", move_count); end
        checks++; if ({xoroin, rowin, colin, ai_en, busy, game_over, reject} !== 10'd0) begin
            errors++; $display("FAIL reset_zero_outs: got %b expected all zero", {xoroin, rowin, colin, ai_en, busy, game_over, reject}); end
        resetb = 1'b1;
        @(negedge ph1);
        checks++; if (core_reset !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL init_hold: got core_reset=%0b busy=%0b expected 1 1", core_reset, busy); end
        @(negedge ph1);
        checks++; if (core_reset !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL init_exit: got core_reset=%0b busy=%0b expected 0 0", core_reset, busy); end
    endtask

    task automatic test_place_basic();
        sw_row = 2'd1; sw_col = 2'd2; core_err = 1'b0; core_win = 2'b00; ai_mode = 1'b0;
        run_seq(0, 30, -1, -1, 0, 70);
        checks++; if (issue_cnt != 1) begin errors++; $display("FAIL place_issue_cycles: got %0d expected 1", issue_cnt); end
        checks++; if ({iss_x, iss_row, iss_col, iss_ai} !== {2'b01, 2'd1, 2'd2, 1'b0}) begin
            errors++; $display("FAIL place_issue_fields: got x=%0b r=%0d c=%0d ai=%0b expected x=01 r=1 c=2 ai=0", iss_x, iss_row, iss_col, iss_ai); end
        checks++; if (turn !== 2'b10 || move_count !== 4'd1) begin errors++; $display("FAIL place_result: got turn=%0b count=%0d expected 10 1", turn, move_count); end
        checks++; if (reject_cnt != 0 || busy !== 1'b0) begin errors++; $display("FAIL place_quiet: got rejects=%0d busy=%0b expected 0 0", reject_cnt, busy); end
    endtask

    task automatic test_new_game();
        run_seq(-1, -1, 0, 30, 0, 60);
        checks++; if (rst_cycles != 2) begin errors++; $display("FAIL new_core_reset_len: got %0d expected 2", rst_cycles); end
        checks++; if (turn !== 2'b01 || move_count !== 4'd0 || game_over !== 1'b0) begin
            errors++; $display("FAIL new_clear: got turn=%0b count=%0d over=%0b expected 01 0 0", turn, move_count, game_over); end
    endtask

    task automatic test_core_reject();
        sw_row = 2'd0; sw_col = 2'd0; core_err = 1'b1;
        run_seq(0, 30, -1, -1, 0, 70);
        core_err = 1'b0;
        checks++; if (issue_cnt != 1 || reject_cnt != 1) begin errors++; $display("FAIL err_reject: got issues=%0d rejects=%0d expected 1 1", issue_cnt, reject_cnt); end
        checks++; if (turn !== 2'b01 || move_count !== 4'd0) begin errors++; $display("FAIL err_state: got turn=%0b count=%0d expected 01 0", turn, move_count); end
    endtask

    task automatic test_invalid_coord();
        sw_row = 2'd3; sw_col = 2'd0;
        run_seq(0, 30, -1, -1, 0, 70);
        checks++; if (reject_cnt != 1 || issue_cnt != 0 || busy_seen != 0) begin
            errors++; $display("FAIL bad_row: got rejects=%0d issues=%0d busy_cycles=%0d expected 1 0 0", reject_cnt, issue_cnt, busy_seen); end
        sw_row = 2'd2; sw_col = 2'd3;
        run_seq(0, 30, -1, -1, 0, 70);
        checks++; if (reject_cnt != 1 || issue_cnt != 0 || move_count !== 4'd0) begin
            errors++; $display("FAIL bad_col: got rejects=%0d issues=%0d count=%0d expected 1 0 0", reject_cnt, issue_cnt, move_count); end
    endtask

    task automatic test_ai_reply();
        ai_mode = 1'b1; sw_row = 2'd1; sw_col = 2'd1;
        run_seq(0, 30, -1, -1, 2, 70);
        checks++; if (iss_c < 0 || iss_ai !== 1'b1 || iss_x !== 2'b01) begin errors++; $display("FAIL ai_issue: got at=%0d ai_en=%0b x=%0b expected ai_en=1 x=01", iss_c, iss_ai, iss_x); end
        else begin
            checks++; if (turn_log[iss_c+2] !== 2'b10 || turn_log[iss_c+3] !== 2'b01 || busy_log[iss_c+3] !== 1'b0) begin
                errors++; $display("FAIL ai_reply_timing: got turn %0b->%0b busy=%0b expected 10->01 busy 0", turn_log[iss_c+2], turn_log[iss_c+3], busy_log[iss_c+3]); end
        end
        checks++; if (move_count !== 4'd2 || turn !== 2'b01) begin errors++; $display("FAIL ai_reply_result: got count=%0d turn=%0b expected 2 01", move_count, turn); end
    endtask

    task automatic test_ai_timeout();
        ai_mode = 1'b1; sw_row = 2'd2; sw_col = 2'd2;
        run_seq(0, 30, -1, -1, 0, 70);
        checks++; if (iss_c < 0) begin errors++; $display("FAIL ai_timeout_issue: got no issue expected 1"); end
        else begin
            checks++; if (turn_log[iss_c+9] !== 2'b10 || busy_log[iss_c+9] !== 1'b1) begin
                errors++; $display("FAIL ai_timeout_wait: got turn=%0b busy=%0b expected 10 1", turn_log[iss_c+9], busy_log[iss_c+9]); end
            checks++; if (turn_log[iss_c+10] !== 2'b01 || busy_log[iss_c+10] !== 1'b0) begin
                errors++; $display("FAIL ai_timeout_exit: got turn=%0b busy=%0b expected 01 0", turn_log[iss_c+10], busy_log[iss_c+10]); end
        end
        checks++; if (move_count !== 4'd3) begin errors++; $display("FAIL ai_timeout_count: got %0d expected 3", move_count); end
    endtask

    task automatic test_win_done();
        ai_mode = 1'b0; sw_row = 2'd0; sw_col = 2'd1; core_win = 2'b01;
        run_seq(0, 30, -1, -1, 0, 70);
        core_win = 2'b00;
        checks++; if (game_over !== 1'b1 || move_count !== 4'd4 || busy !== 1'b0) begin
            errors++; $display("FAIL win_done: got over=%0b count=%0d busy=%0b expected 1 4 0", game_over, move_count, busy); end
        sw_row = 2'd2; sw_col = 2'd0;
        run_seq(0, 30, -1, -1, 0, 70);
        checks++; if (issue_cnt != 0 || reject_cnt != 0 || game_over !== 1'b1 || move_count !== 4'd4) begin
            errors++; $display("FAIL done_ignores_place: got issues=%0d rejects=%0d over=%0b count=%0d expected 0 0 1 4", issue_cnt, reject_cnt, game_over, move_count); end
    endtask

    task automatic test_new_mid_ai();
        ai_mode = 1'b1; sw_row = 2'd0; sw_col = 2'd2;
        run_seq(0, 30, 5, 35, 0, 80);
        checks++; if (issue_cnt != 1 || first_rst_c < 1) begin errors++; $display("FAIL mid_ai_setup: got issues=%0d reset_at=%0d expected 1 >0", issue_cnt, first_rst_c); end
        else begin
            checks++; if (turn_log[first_rst_c-1] !== 2'b10 || busy_log[first_rst_c-1] !== 1'b1) begin
                errors++; $display("FAIL mid_ai_preempt: got turn=%0b busy=%0b expected 10 1", turn_log[first_rst_c-1], busy_log[first_rst_c-1]); end
        end
        checks++; if (rst_cycles != 2 || move_count !== 4'd0 || turn !== 2'b01 || game_over !== 1'b0) begin
            errors++; $display("FAIL mid_ai_new: got rst=%0d count=%0d turn=%0b over=%0b expected 2 0 01 0", rst_cycles, move_count, turn, game_over); end
    endtask

    initial begin
        test_reset();
        test_place_basic();
        test_new_game();
        test_core_reject();
        test_invalid_coord();
        test_ai_reply();
        test_ai_timeout();
        test_win_done();
        test_new_game();
        test_new_mid_ai();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/tictactoe_move_entry.md
Name: tictactoe_move_entry

Overview:
- Upstream stage of the tictactoe game core. It converts the player's raw switches and buttons into single-cycle move requests on the core's xoroin/rowin/colin inputs.
- Tracks whose turn it is, waits for the core's err/win response, and in AI mode waits for the core's reply move.
- Drives the core's active-high reset and ai_en.

Parameters:
- DEB_CYCLES, 16: number of consecutive stable synchronized samples needed before a button level is accepted.
- RESP_LAT, 1: cycles from the ISSUE cycle to the cycle in which core_err and core_win are sampled.
- AI_TIMEOUT, 8: maximum cycles to wait for the AI reply move.

Ports:
- ph1  in  1  single system clock, rising-edge.
- resetb  in  1  synchronous, active-low reset.
- sw_row  in  2  player row select; valid values 0..2.
- sw_col  in  2  player column select; valid values 0..2.
- btn_place  in  1  raw, asynchronous "place mark" button.
- btn_new  in  1  raw, asynchronous "new game" button.
- ai_mode  in  1  when 1, O is played by the core AI.
- core_err  in  1  core rejected the move.
- core_win  in  2  game result: 00 none, 01 X, 10 O, 11 draw.
- core_xoro  in  2  core move echo; 10 indicates an AI O move.
- core_reset  out  1  active-high reset to the core.
- xoroin  out  2  mark to place: 00 none, 01 X, 10 O.
- rowin  out  2  row of the move.
- colin  out  2  column of the move.
- ai_en  out  1  AI enable to the core.
- turn  out  2  side to move: 01 X, 10 O.
- busy  out  1  move in flight.
- game_over  out  1  result reached.
- reject  out  1  one-cycle pulse on a rejected move.
- move_count  out  4  accepted moves, 0..9.

Behaviour:
- Reset (resetb=0 at a rising edge of ph1):
  - State becomes INIT.
  - core_reset=1, turn=01, move_count=0.
  - xoroin, rowin, colin, ai_en, busy, game_over and reject are all 0.
  - Debouncer state is cleared.
- Buttons:
  - Each button passes through a 2-flop synchronizer, then the debouncer.
  - Action fires on the debounced rising edge only.
  - Edges that arrive while busy=1 are dropped, not queued.
- xoroin is 00 in every cycle except ISSUE. rowin/colin hold their last values.
- States:
  - INIT: core_reset=1 for 2 cycles, then WAIT_PRESS with turn=01.
  - WAIT_PRESS: busy=0. On a place edge:
    - If sw_row==3 or sw_col==3: reject pulse, stay in WAIT_PRESS.
    - Otherwise: latch row/col, go to ISSUE.
  - ISSUE: exactly 1 cycle. xoroin=turn, rowin/colin=latched values, ai_en=ai_mode. Then go to WAIT_RESP.
  - WAIT_RESP: count RESP_LAT cycles, then sample core_err and core_win.
    - core_err=1: reject pulse, turn unchanged, go to WAIT_PRESS.
    - core_err=0: move_count+1.
      - core_win!=00: go to DONE.
      - ai_mode=1 and turn==01: turn=10, go to AI_WAIT.
      - Otherwise: toggle turn, go to WAIT_PRESS.
  - AI_WAIT: wait for core_xoro==10.
    - On arrival: move_count+1, turn=01. Then core_win!=00 → DONE, else WAIT_PRESS.
    - After AI_TIMEOUT cycles with no AI move: turn=01, go to WAIT_PRESS; move_count unchanged.
  - DONE: game_over=1, busy=0. Place edges are ignored.
- busy=1 in INIT, ISSUE, WAIT_RESP and AI_WAIT.
- A btn_new edge in any state, including mid-move, goes to INIT. It clears turn, move_count and game_over, takes priority over every other transition, and is never blocked by busy.
- move_count saturates at 9.
- A core_win=11 (draw) result is handled exactly like a win: go to DONE.

Optional Feature:
- Macro: MOVE_ENTRY_LOCAL_CHECK_EN.
- Defined:
  - Keep a local 9-cell occupancy map, set on every accepted move, including AI moves indexed by the core_xoro cycle's rowin/colin echo.
  - A place on an occupied cell gives a reject pulse in WAIT_PRESS without issuing to the core.
  - The map is cleared in INIT.
- Undefined: every in-range move is issued, and occupancy is judged only by core_err.

Decomposition:
- Package tictactoe_pkg: mark encodings (EMPTY=00, X=01, O=10), win encodings (NONE, XWIN, OWIN, DRAW), the entry state enum, and the invalid-coordinate constant 3.
- One sub-module, button_debounce (synchronizer plus DEB_CYCLES counter, rising-edge pulse output), instantiated twice.

Test Plan:
- Reset, then place (1,2) → after debounce one ISSUE cycle with xoroin=01, rowin=1, colin=2; core_err=0, core_win=00 → turn=10, move_count=1.
- Place (0,0) with core_err=1 → reject pulse; turn stays 01; move_count stays 0.
- sw_row=3 then place → reject pulse; xoroin never leaves 00; busy stays 0.
- ai_mode=1: X at (1,1), core_xoro=10 two cycles later → move_count=2, turn=01.
- ai_mode=1: no AI reply → after AI_TIMEOUT=8 cycles turn=01, back to WAIT_PRESS.
- Core returns core_win=01 → game_over=1 and further places are ignored; btn_new mid-AI_WAIT → core_reset high for 2 cycles, move_count=0, turn=01.
